// File: rtl/pci_pa_count_pkg.sv
// pci_pa_count_pkg: shared constants for the packet-analysis counter register block.
// Holds the register offsets, the counter index map, and the CTRL/STATUS bit positions.
package pci_pa_count_pkg;

  localparam int NUM_CNT = 17;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;

  // Byte offsets of the software-visible registers
  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_STATUS    = 8'h04;
  localparam logic [7:0] REG_PERIOD    = 8'h08;
  localparam logic [7:0] REG_SNAP_BASE = 8'h40;

  // Word indices (byte address bits [7:2]) used by the decoder
  localparam logic [5:0] WORD_CTRL   = REG_CTRL[7:2];
  localparam logic [5:0] WORD_STATUS = REG_STATUS[7:2];
  localparam logic [5:0] WORD_PERIOD = REG_PERIOD[7:2];
  localparam int         WORD_SNAP0  = 16;

  // Counter indices: 0..15 are CQ request type codes, 16 counts CC completions
  localparam int CNT_IDX_MEM_RD    = 0;
  localparam int CNT_IDX_MEM_WR    = 1;
  localparam int CNT_IDX_IO_RD     = 2;
  localparam int CNT_IDX_IO_WR     = 3;
  localparam int CNT_IDX_MEM_FADD  = 4;
  localparam int CNT_IDX_MEM_SWAP  = 5;
  localparam int CNT_IDX_MEM_CAS   = 6;
  localparam int CNT_IDX_LOCK_RD   = 7;
  localparam int CNT_IDX_CFG_RD0   = 8;
  localparam int CNT_IDX_CFG_RD1   = 9;
  localparam int CNT_IDX_CFG_WR0   = 10;
  localparam int CNT_IDX_CFG_WR1   = 11;
  localparam int CNT_IDX_MSG       = 12;
  localparam int CNT_IDX_MSG_VD    = 13;
  localparam int CNT_IDX_MSG_ATS   = 14;
  localparam int CNT_IDX_RSVD      = 15;
  localparam int CNT_IDX_CMP       = 16;

  // CTRL bit positions
  localparam int CTRL_ENABLE_BIT     = 0;
  localparam int CTRL_CLEAR_BIT      = 1;
  localparam int CTRL_SNAP_BIT       = 2;
  localparam int CTRL_AUTO_CLEAR_BIT = 3;

  // STATUS bit positions
  localparam int STATUS_SNAP_VALID_BIT = 0;
  localparam int STATUS_CLEAR_BUSY_BIT = 1;
  localparam int STATUS_SEQ_LSB        = 16;

  // Clear-pulse sequencer states
  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_PULSE = 1'b1
  } clr_state_t;

  // Word index of a byte address; the two low bits are ignored
  function automatic logic [5:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr[7:2];
  endfunction

endpackage

// File: rtl/pci_pa_count_reg_if.sv
// pci_pa_count_reg_if: req/ack register port between software and the counter block.
interface pci_pa_count_reg_if;
  import pci_pa_count_pkg::*;

  logic              reg_wr_req;
  logic              reg_rd_req;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_ack;

  modport master (
    output reg_wr_req, reg_rd_req, reg_addr, reg_wdata,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_wr_req, reg_rd_req, reg_addr, reg_wdata,
    output reg_rdata, reg_ack
  );

endinterface

// File: rtl/pci_pa_count_timer.sv
// pci_pa_count_timer: free-running interval timer that emits a one-cycle tick every
// PERIOD cycles while enabled. Writing PERIOD or dropping enable restarts it from 0.
module pci_pa_count_timer (
  input  logic        user_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic        period_wr,
  output logic        tick
);

  logic [31:0] timer_q, timer_d;

  // Count up to PERIOD-1, tick there and wrap; any reconfiguration zeroes the count
  always_comb begin
    tick    = 1'b0;
    timer_d = timer_q;
    if (period_wr || !enable) begin
      timer_d = '0;
    end else if (period != '0) begin
      if (timer_q == period - 32'd1) begin
        tick    = 1'b1;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 32'd1;
      end
    end
  end

  // Timer register
  always_ff @(posedge user_clk) begin
    if (!reset_n) timer_q <= '0;
    else          timer_q <= timer_d;
  end

endmodule

// File: rtl/pci_pa_count_reg.sv
// pci_pa_count_reg: register front-end for the PCIe completer packet-analysis counters.
// Drives counter enable/clear, captures all counts atomically into a snapshot bank and
// serves reads of that bank over a req/ack port.
// Optional feature macro: PCI_PA_COUNT_PERIODIC_EN (PERIOD register, interval timer,
// AUTO_CLEAR). Without it offset 0x08 reads 0 and AUTO_CLEAR is ignored.
module pci_pa_count_reg #(
  parameter int NUM_CNT          = pci_pa_count_pkg::NUM_CNT,
  parameter int RST_PULSE_CYCLES = 4
) (
  input  logic                  user_clk,
  input  logic                  reset_n,
  input  logic [NUM_CNT*32-1:0] cnt_bus,
  output logic                  pa_count_enable,
  output logic                  pa_count_reset,
  pci_pa_count_reg_if.slave     reg_bus
);
  import pci_pa_count_pkg::*;

  localparam logic [3:0] PULSE_RELOAD = 4'(RST_PULSE_CYCLES - 1);

  logic        wr_req, rd_req, wr_ctrl, clear_req, snap_pulse, tick;
  logic [5:0]  req_word;
  logic [31:0] wdata, rd_mux;
  logic        unused_bits;

  clr_state_t  clr_state_q, clr_state_d;
  logic [3:0]  clr_cnt_q, clr_cnt_d;
  logic        enable_q, enable_d;
  logic [15:0] snap_seq_q, snap_seq_d;
  logic        snap_valid_q, snap_valid_d;
  logic [31:0] snap_q [NUM_CNT];
  logic [31:0] snap_d [NUM_CNT];
  logic        rd_pend_q, rd_pend_d;
  logic [5:0]  rd_word_q, rd_word_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;

  assign wr_req      = reg_bus.reg_wr_req;
  assign rd_req      = reg_bus.reg_rd_req;
  assign wdata       = reg_bus.reg_wdata;
  assign req_word    = word_idx(reg_bus.reg_addr);
  assign wr_ctrl     = wr_req && (req_word == WORD_CTRL);
  assign unused_bits = ^{wdata, reg_bus.reg_addr[1:0]};

`ifdef PCI_PA_COUNT_PERIODIC_EN
  logic        auto_clear_q, auto_clear_d;
  logic [31:0] period_q, period_d;
  logic        wr_period;

  assign wr_period = wr_req && (req_word == WORD_PERIOD);
  assign clear_req = (wr_ctrl && wdata[CTRL_CLEAR_BIT]) || (tick && auto_clear_q);

  pci_pa_count_timer u_timer (
    .user_clk  (user_clk),
    .reset_n   (reset_n),
    .enable    (enable_q),
    .period    (period_q),
    .period_wr (wr_period),
    .tick      (tick)
  );
`else
  assign tick      = 1'b0;
  assign clear_req = wr_ctrl && wdata[CTRL_CLEAR_BIT];
`endif

  // A manual SNAP and a timer tick in the same cycle collapse into one capture
  assign snap_pulse = (wr_ctrl && wdata[CTRL_SNAP_BIT]) || tick;

  // Clear sequencer: hold the pulse for RST_PULSE_CYCLES, a new CLEAR restarts the count
  always_comb begin
    clr_state_d = clr_state_q;
    clr_cnt_d   = clr_cnt_q;
    case (clr_state_q)
      CLR_IDLE: begin
        if (clear_req) begin
          clr_state_d = CLR_PULSE;
          clr_cnt_d   = PULSE_RELOAD;
        end
      end
      CLR_PULSE: begin
        if (clear_req)               clr_cnt_d   = PULSE_RELOAD;
        else if (clr_cnt_q == 4'd0)  clr_state_d = CLR_IDLE;
        else                         clr_cnt_d   = clr_cnt_q - 4'd1;
      end
      default: clr_state_d = CLR_IDLE;
    endcase
  end

  // Control bits, snapshot bank and sequence number
  always_comb begin
    enable_d     = wr_ctrl ? wdata[CTRL_ENABLE_BIT] : enable_q;
    snap_seq_d   = snap_pulse ? snap_seq_q + 16'd1 : snap_seq_q;
    snap_valid_d = snap_valid_q || snap_pulse;
    for (int i = 0; i < NUM_CNT; i++) begin
      snap_d[i] = snap_pulse ? cnt_bus[32*i +: 32] : snap_q[i];
    end
`ifdef PCI_PA_COUNT_PERIODIC_EN
    auto_clear_d = wr_ctrl ? wdata[CTRL_AUTO_CLEAR_BIT] : auto_clear_q;
    period_d     = wr_period ? wdata : period_q;
`endif
  end

  // Read path: address latched in the request cycle, data muxed and registered next cycle
  always_comb begin
    rd_mux = '0;
    case (rd_word_q)
      WORD_CTRL: begin
        rd_mux[CTRL_ENABLE_BIT] = enable_q;
`ifdef PCI_PA_COUNT_PERIODIC_EN
        rd_mux[CTRL_AUTO_CLEAR_BIT] = auto_clear_q;
`endif
      end
      WORD_STATUS: begin
        rd_mux[STATUS_SNAP_VALID_BIT]             = snap_valid_q;
        rd_mux[STATUS_CLEAR_BUSY_BIT]             = (clr_state_q == CLR_PULSE);
        rd_mux[STATUS_SEQ_LSB +: 16]              = snap_seq_q;
      end
`ifdef PCI_PA_COUNT_PERIODIC_EN
      WORD_PERIOD: rd_mux = period_q;
`endif
      default: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (rd_word_q == 6'(WORD_SNAP0 + i)) rd_mux = snap_q[i];
        end
      end
    endcase
    rd_pend_d = rd_req && !wr_req;
    rd_word_d = req_word;
    ack_d     = wr_req || rd_pend_q;
    rdata_d   = rd_pend_q ? rd_mux : '0;
  end

  // All state registers with synchronous active-low reset
  always_ff @(posedge user_clk) begin
    if (!reset_n) begin
      clr_state_q  <= CLR_IDLE;
      clr_cnt_q    <= '0;
      enable_q     <= 1'b0;
      snap_seq_q   <= '0;
      snap_valid_q <= 1'b0;
      for (int i = 0; i < NUM_CNT; i++) snap_q[i] <= '0;
      rd_pend_q    <= 1'b0;
      rd_word_q    <= '0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
`ifdef PCI_PA_COUNT_PERIODIC_EN
      auto_clear_q <= 1'b0;
      period_q     <= '0;
`endif
    end else begin
      clr_state_q  <= clr_state_d;
      clr_cnt_q    <= clr_cnt_d;
      enable_q     <= enable_d;
      snap_seq_q   <= snap_seq_d;
      snap_valid_q <= snap_valid_d;
      snap_q       <= snap_d;
      rd_pend_q    <= rd_pend_d;
      rd_word_q    <= rd_word_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
`ifdef PCI_PA_COUNT_PERIODIC_EN
      auto_clear_q <= auto_clear_d;
      period_q     <= period_d;
`endif
    end
  end

  // The clear pulse is cut as soon as reset is asserted rather than finishing its count
  assign pa_count_reset    = (clr_state_q == CLR_PULSE) && reset_n;
  assign pa_count_enable   = enable_q;
  assign reg_bus.reg_rdata = rdata_q;
  assign reg_bus.reg_ack   = ack_q;

endmodule
